// File: rtl/ag32gbd_bus_master.sv
// Game Boy cartridge-bus initiator: turns single-byte host requests into one
// timed cartridge bus cycle (setup, strobe, hold) on the cartridge connector.
module ag32gbd_bus_master #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 6,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic        sys_clock,
    input  logic        sys_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] Cart_a,
    output logic [7:0]  Cart_d_out,
    output logic        Cart_d_oe,
    input  logic [7:0]  Cart_d_in,
    output logic        Cart_nRD,
    output logic        Cart_nWR,
    output logic        Cart_nCS
);

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255 ||
        STROBE_CYCLES < 1 || STROBE_CYCLES > 255 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_timing
        $error("ag32gbd_bus_master: phase lengths must be in 1..255");
    end

    localparam logic [7:0] LD_SETUP  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] LD_STROBE = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] LD_HOLD   = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_write;
    logic        w_accept;
    logic        w_phase_end;
    logic        w_strobe_end;
    logic        w_hold_end;

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;
    logic [15:0] r_cart_a;
    logic [7:0]  r_cart_d_out;
    logic        r_cart_d_oe;
    logic        r_cart_nrd;
    logic        r_cart_nwr;
    logic        r_cart_ncs;

    assign w_accept     = req_valid && r_req_ready;
    assign w_phase_end  = (r_cnt == 8'd0);
    assign w_strobe_end = (r_state == STROBE) && w_phase_end;
    assign w_hold_end   = (r_state == HOLD) && w_phase_end;

    // Each phase loads its length minus one and leaves when the counter hits zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = LD_SETUP;
                end
            end
            SETUP: begin
                if (w_phase_end) begin
                    w_state_nxt = STROBE;
                    w_cnt_nxt   = LD_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            STROBE: begin
                if (w_phase_end) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = LD_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            HOLD: begin
                if (w_phase_end) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (w_accept) begin
            r_write <= req_write;
        end
    end

    // Outputs are registered from the next state so strobes never glitch.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 8'h00;
            r_cart_a     <= 16'h0000;
            r_cart_d_out <= 8'h00;
            r_cart_d_oe  <= 1'b0;
            r_cart_nrd   <= 1'b1;
            r_cart_nwr   <= 1'b1;
            r_cart_ncs   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_cart_nrd  <= !((w_state_nxt == STROBE) && !r_write);
            r_cart_nwr  <= !((w_state_nxt == STROBE) && r_write);
            r_rsp_valid <= w_strobe_end;
            if (w_strobe_end && !r_write) begin
                r_rsp_rdata <= Cart_d_in;
            end
            if (w_accept) begin
                r_cart_a   <= req_addr;
                r_cart_ncs <= (req_addr[15:13] != 3'b101);
                if (req_write) begin
                    r_cart_d_out <= req_wdata;
                    r_cart_d_oe  <= 1'b1;
                end
            end else if (w_hold_end) begin
                r_cart_ncs  <= 1'b1;
                r_cart_d_oe <= 1'b0;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign Cart_a     = r_cart_a;
    assign Cart_d_out = r_cart_d_out;
    assign Cart_d_oe  = r_cart_d_oe;
    assign Cart_nRD   = r_cart_nrd;
    assign Cart_nWR   = r_cart_nwr;
    assign Cart_nCS   = r_cart_ncs;

endmodule

// File: tb/tb_ag32gbd_bus_master.sv
// Bench for ag32gbd_bus_master: default-timing and 1/1/1-timing instances checked
// every cycle against a time-since-accept model, plus hand-computed cycle checks.
module tb_ag32gbd_bus_master;

    localparam int S0 = 2, W0 = 6, H0 = 2;
    localparam int S1 = 1, W1 = 1, H1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        vld[2], wr[2], rdy[2], rspv[2], oe[2], nrd[2], nwr[2], ncs[2];
    logic [15:0] addr[2], ca[2];
    logic [7:0]  wdat[2], din[2], rdat[2], dout[2];

    ag32gbd_bus_master #(.SETUP_CYCLES(S0), .STROBE_CYCLES(W0), .HOLD_CYCLES(H0)) u_dut0 (
        .sys_clock(clk), .sys_reset(rst),
        .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(wr[0]),
        .req_addr(addr[0]), .req_wdata(wdat[0]),
        .rsp_valid(rspv[0]), .rsp_rdata(rdat[0]),
        .Cart_a(ca[0]), .Cart_d_out(dout[0]), .Cart_d_oe(oe[0]), .Cart_d_in(din[0]),
        .Cart_nRD(nrd[0]), .Cart_nWR(nwr[0]), .Cart_nCS(ncs[0])
    );

    ag32gbd_bus_master #(.SETUP_CYCLES(S1), .STROBE_CYCLES(W1), .HOLD_CYCLES(H1)) u_dut1 (
        .sys_clock(clk), .sys_reset(rst),
        .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(wr[1]),
        .req_addr(addr[1]), .req_wdata(wdat[1]),
        .rsp_valid(rspv[1]), .rsp_rdata(rdat[1]),
        .Cart_a(ca[1]), .Cart_d_out(dout[1]), .Cart_d_oe(oe[1]), .Cart_d_in(din[1]),
        .Cart_nRD(nrd[1]), .Cart_nWR(nwr[1]), .Cart_nCS(ncs[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, act, exp);
    endtask

    // Model: a transaction is described only by its accept edge; outputs follow
    // from how many edges have elapsed since then.
    int          m_e = 0;
    int          m_k[2] = '{0, 0};
    bit          m_has[2] = '{1'b0, 1'b0};
    logic        m_w[2];
    logic [15:0] m_a[2];
    logic [7:0]  m_wd[2];
    logic [7:0]  m_rd[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_has[i] <= 1'b0;
                m_a[i]   <= 16'h0000;
                m_rd[i]  <= 8'h00;
            end
        end else begin
            m_e <= m_e + 1;
            for (int i = 0; i < 2; i++) begin
                if (m_has[i] && !m_w[i] &&
                    (m_e + 1 - m_k[i]) == ((i == 0) ? S0 + W0 : S1 + W1))
                    m_rd[i] <= din[i];
                if (vld[i] && (!m_has[i] ||
                    (m_e + 1 - m_k[i]) >= ((i == 0) ? S0 + W0 + H0 + 1 : S1 + W1 + H1 + 1))) begin
                    m_has[i] <= 1'b1;
                    m_k[i]   <= m_e + 1;
                    m_w[i]   <= wr[i];
                    m_a[i]   <= addr[i];
                    m_wd[i]  <= wdat[i];
                end
            end
        end
    end

    task automatic check_cycle(input int i);
        int   s, w, h, d;
        logic busy, in_ram, strobe;
        s = (i == 0) ? S0 : S1;
        w = (i == 0) ? W0 : W1;
        h = (i == 0) ? H0 : H1;
        d = m_e - m_k[i];
        busy   = m_has[i] && (d < s + w + h);
        in_ram = (m_a[i] >= 16'hA000) && (m_a[i] <= 16'hBFFF);
        strobe = busy && (d >= s) && (d < s + w);
        chk("req_ready", i, rdy[i], !busy);
        chk("rsp_valid", i, rspv[i], busy && (d == s + w));
        chk("rsp_rdata", i, rdat[i], m_rd[i]);
        chk("Cart_a", i, ca[i], m_a[i]);
        chk("Cart_nCS", i, ncs[i], !(busy && in_ram));
        chk("Cart_d_oe", i, oe[i], busy && m_w[i]);
        chk("Cart_nRD", i, nrd[i], !(strobe && !m_w[i]));
        chk("Cart_nWR", i, nwr[i], !(strobe && m_w[i]));
        if (busy && m_w[i]) chk("Cart_d_out", i, dout[i], m_wd[i]);
    endtask

    always @(negedge clk) begin
        check_cycle(0);
        check_cycle(1);
    end

    // Per-cycle log of the instance under directed test; index 1 = cycle after accept.
    int          cur = 0;
    logic [15:0] lg_a[32];
    logic [7:0]  lg_rdat[32], lg_dout[32];
    logic        lg_rdy[32], lg_rsp[32], lg_oe[32], lg_nrd[32], lg_nwr[32], lg_ncs[32];

    task automatic step(input int i);
        if (cur < 32) begin
            lg_a[cur]    = ca[i];
            lg_rdat[cur] = rdat[i];
            lg_dout[cur] = dout[i];
            lg_rdy[cur]  = rdy[i];
            lg_rsp[cur]  = rspv[i];
            lg_oe[cur]   = oe[i];
            lg_nrd[cur]  = nrd[i];
            lg_nwr[cur]  = nwr[i];
            lg_ncs[cur]  = ncs[i];
        end
        cur++;
        @(negedge clk);
    endtask

    task automatic issue(input int i, input logic w, input logic [15:0] a,
                         input logic [7:0] wd, input logic hold);
        @(negedge clk);
        vld[i] = 1'b1; wr[i] = w; addr[i] = a; wdat[i] = wd;
        @(negedge clk);
        if (!hold) vld[i] = 1'b0;
        cur = 1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; wr[i] = 1'b0; addr[i] = 16'h0000; wdat[i] = 8'h00; din[i] = 8'h00;
        end
        vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h1234; wdat[0] = 8'h55;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 0, rdy[0], 1'b1);
            chk("rst_ncs", 0, ncs[0], 1'b1);
            chk("rst_a", 0, ca[0], 16'h0000);
            chk("rst_oe", 0, oe[0], 1'b0);
        end
        vld[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 0, rdy[0], 1'b1);
        chk("post_rst_a", 0, ca[0], 16'h0000);

        // Read 0xA000 with 0x5A on the bus
        din[0] = 8'h5A;
        issue(0, 1'b0, 16'hA000, 8'h00, 1'b0);
        repeat (12) step(0);
        chk("rd_ncs1", 0, lg_ncs[1], 1'b0);
        chk("rd_ncs10", 0, lg_ncs[10], 1'b0);
        chk("rd_ncs11", 0, lg_ncs[11], 1'b1);
        chk("rd_nrd2", 0, lg_nrd[2], 1'b1);
        chk("rd_nrd3", 0, lg_nrd[3], 1'b0);
        chk("rd_nrd8", 0, lg_nrd[8], 1'b0);
        chk("rd_nrd9", 0, lg_nrd[9], 1'b1);
        chk("rd_rsp8", 0, lg_rsp[8], 1'b0);
        chk("rd_rsp9", 0, lg_rsp[9], 1'b1);
        chk("rd_rsp10", 0, lg_rsp[10], 1'b0);
        chk("rd_data9", 0, lg_rdat[9], 8'h5A);
        chk("rd_rdy10", 0, lg_rdy[10], 1'b0);
        chk("rd_rdy11", 0, lg_rdy[11], 1'b1);
        chk("rd_oe5", 0, lg_oe[5], 1'b0);

        // Write 0x0A to 0x0000
        issue(0, 1'b1, 16'h0000, 8'h0A, 1'b0);
        repeat (12) step(0);
        chk("wr_oe1", 0, lg_oe[1], 1'b1);
        chk("wr_dout1", 0, lg_dout[1], 8'h0A);
        chk("wr_oe10", 0, lg_oe[10], 1'b1);
        chk("wr_oe11", 0, lg_oe[11], 1'b0);
        chk("wr_ncs5", 0, lg_ncs[5], 1'b1);
        chk("wr_nwr2", 0, lg_nwr[2], 1'b1);
        chk("wr_nwr3", 0, lg_nwr[3], 1'b0);
        chk("wr_nwr8", 0, lg_nwr[8], 1'b0);
        chk("wr_nwr9", 0, lg_nwr[9], 1'b1);
        chk("wr_nrd5", 0, lg_nrd[5], 1'b1);
        chk("wr_rsp9", 0, lg_rsp[9], 1'b1);
        chk("wr_rdata9", 0, lg_rdat[9], 8'h5A);
        chk("wr_rdy11", 0, lg_rdy[11], 1'b1);

        // Back-to-back: write 0x4000/0x03 then read 0xA123 with req_valid held
        issue(0, 1'b1, 16'h4000, 8'h03, 1'b1);
        wr[0] = 1'b0; addr[0] = 16'hA123; din[0] = 8'h3C;
        while (cur < 12) step(0);
        vld[0] = 1'b0;
        repeat (13) step(0);
        chk("b2b_a11", 0, lg_a[11], 16'h4000);
        chk("b2b_a12", 0, lg_a[12], 16'hA123);
        chk("b2b_rdy11", 0, lg_rdy[11], 1'b1);
        chk("b2b_rdy12", 0, lg_rdy[12], 1'b0);
        chk("b2b_ncs1", 0, lg_ncs[1], 1'b1);
        chk("b2b_ncs12", 0, lg_ncs[12], 1'b0);
        chk("b2b_nwr8", 0, lg_nwr[8], 1'b0);
        chk("b2b_oe10", 0, lg_oe[10], 1'b1);
        chk("b2b_oe11", 0, lg_oe[11], 1'b0);
        chk("b2b_nrd14", 0, lg_nrd[14], 1'b0);
        chk("b2b_rsp20", 0, lg_rsp[20], 1'b1);
        chk("b2b_rdata20", 0, lg_rdat[20], 8'h3C);
        chk("b2b_rdy22", 0, lg_rdy[22], 1'b1);

        // Reset in the 4th strobe cycle of a read
        din[0] = 8'h77;
        issue(0, 1'b0, 16'hB000, 8'h00, 1'b0);
        repeat (4) step(0);
        chk("mid_nrd4", 0, lg_nrd[4], 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_nrd", 0, nrd[0], 1'b1);
        chk("mid_ncs", 0, ncs[0], 1'b1);
        chk("mid_ready", 0, rdy[0], 1'b1);
        chk("mid_a", 0, ca[0], 16'h0000);
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mid_rdata", 0, rdat[0], 8'h00);
        din[0] = 8'h66;
        issue(0, 1'b0, 16'hA055, 8'h00, 1'b0);
        repeat (12) step(0);
        chk("re_nrd2", 0, lg_nrd[2], 1'b1);
        chk("re_nrd3", 0, lg_nrd[3], 1'b0);
        chk("re_rsp9", 0, lg_rsp[9], 1'b1);
        chk("re_rdata9", 0, lg_rdat[9], 8'h66);
        chk("re_rdy10", 0, lg_rdy[10], 1'b0);
        chk("re_rdy11", 0, lg_rdy[11], 1'b1);

        // 1/1/1 instance: data changes during the single strobe cycle
        din[1] = 8'h11;
        issue(1, 1'b0, 16'hA010, 8'h00, 1'b1);
        addr[1] = 16'hA020;
        step(1);
        din[1] = 8'h22;
        while (cur < 5) step(1);
        vld[1] = 1'b0;
        repeat (6) step(1);
        chk("f_nrd1", 1, lg_nrd[1], 1'b1);
        chk("f_nrd2", 1, lg_nrd[2], 1'b0);
        chk("f_nrd3", 1, lg_nrd[3], 1'b1);
        chk("f_rsp3", 1, lg_rsp[3], 1'b1);
        chk("f_rdata3", 1, lg_rdat[3], 8'h22);
        chk("f_rdy4", 1, lg_rdy[4], 1'b1);
        chk("f_a4", 1, lg_a[4], 16'hA010);
        chk("f_a5", 1, lg_a[5], 16'hA020);
        chk("f_rsp7", 1, lg_rsp[7], 1'b1);
        chk("f_rdy8", 1, lg_rdy[8], 1'b1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ag32gbd_bus_master.md
# ag32gbd_bus_master

Game Boy cartridge-bus initiator: accepts single-byte read/write requests from the FPGA-side host logic and drives one complete cartridge bus cycle per request on the cartridge connector (Cart_a, data, nRD, nWR, nCS), with programmable setup/strobe/hold timing. It sits between host logic (camera capture, save-RAM dump/restore) and the cartridge port, acting as the CPU side of the cartridge protocol that the cartridge-side bank/RAM controllers respond to.

## Interface
- SETUP_CYCLES, 2, sys_clock cycles address/nCS are valid before the strobe; range 1..255
- STROBE_CYCLES, 6, cycles nRD or nWR is held low; range 1..255
- HOLD_CYCLES, 2, cycles address/data/nCS are held after the strobe releases; range 1..255
- sys_clock  in  1  single clock; all state and outputs registered on its rising edge
- sys_reset  in  1  asynchronous, active-high reset
- req_valid  in  1  host request present
- req_ready  out  1  block idle; request accepted on the edge where req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  cartridge address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: cycle complete (reads and writes)
- rsp_rdata  out  8  captured read data; valid with rsp_valid on reads, held until next read
- Cart_a  out  16  cartridge address
- Cart_d_out  out  8  data driven to cartridge
- Cart_d_oe  out  1  tristate enable for Cart_d_out (top level builds the inout)
- Cart_d_in  in  8  data from cartridge (synchronized by top level)
- Cart_nRD  out  1  read strobe, active low
- Cart_nWR  out  1  write strobe, active low
- Cart_nCS  out  1  external-RAM select, active low

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. 8-bit down counter times each phase.
- IDLE: req_ready=1, strobes high, Cart_nCS=1, Cart_d_oe=0, Cart_a holds last address. On accept: latch addr/wdata/write, load counter, go SETUP.
- SETUP: Cart_a=addr; Cart_nCS=0 iff addr[15:13]==3'b101 (0xA000-0xBFFF), else 1; for writes Cart_d_out=wdata, Cart_d_oe=1. After SETUP_CYCLES go STROBE.
- STROBE: Cart_nRD=0 (read) or Cart_nWR=0 (write); never both. After STROBE_CYCLES: on the exiting edge register Cart_d_in into rsp_rdata (reads only), go HOLD.
- HOLD: strobes high; Cart_a, Cart_nCS, Cart_d_out, Cart_d_oe unchanged; rsp_valid=1 in the first HOLD cycle only. After HOLD_CYCLES go IDLE.
- req_valid while not ready: ignored, not queued; host holds request until accepted.
- Writes leave rsp_rdata unchanged.
- Reset (any state): async to IDLE; outputs take reset values immediately; in-flight cycle dropped, no rsp_valid.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0x00, Cart_a=0x0000, Cart_d_out=0x00, Cart_d_oe=0, Cart_nRD=1, Cart_nWR=1, Cart_nCS=1.
- Accept at edge k (S=SETUP, W=STROBE, H=HOLD): SETUP cycles k+1..k+S; strobe low cycles k+S+1..k+S+W; read sample at edge k+S+W; rsp_valid in cycle k+S+W+1; IDLE/req_ready=1 in cycle k+S+W+H+1.
- Minimum request period S+W+H+1 cycles (11 with defaults); read latency accept-to-rsp_valid S+W+1 cycles.
- Address, nCS and data stable for whole strobe plus S before and H after; strobe never glitches (registered outputs).
- Counter width 8 bits; parameter 0 or >255 is illegal (elaboration assertion).

## Test plan
- Reset: hold sys_reset 3 cycles with req_valid=1 -> all outputs at reset values, no accept; release -> req_ready=1.
- Read 0xA000, Cart_d_in=0x5A during strobe -> nCS low cycles 1-10, nRD low cycles 3-8, nWR high, oe=0, rsp_valid cycle 9 with rsp_rdata=0x5A, req_ready cycle 11.
- Write 0x0000 data 0x0A -> nCS stays high, oe=1 and Cart_d_out=0x0A cycles 1-10, nWR low cycles 3-8, nRD high, rsp_valid cycle 9, rsp_rdata unchanged.
- req_valid held high for write 0x4000/0x03 then read 0xA123 -> second accept at edge 11, period exactly 11 cycles, address changes only at accept edges.
- sys_reset asserted in 4th strobe cycle of a read -> nRD/nCS high same cycle (async), no rsp_valid, req_ready=1 after release, next read runs full timing.
- Cart_d_in changes 0x11->0x22 one cycle before strobe end, SETUP=1/STROBE=1/HOLD=1 build -> rsp_rdata=0x22, period 4 cycles.
